ntt_stage_sequencer: RTL and testbench
======================================

// Module: ntt_stage_sequencer
// PURPOSE
//  Sequences the N=2048, P=128 NTT datapath through all LOG_N butterfly stages.
//  Each stage streams N/P=16 address beats to the memory and butterfly array.
//  Writes are regenerated PIPE_LAT cycles after the matching read, and the
//  sequencer drains the pipeline before the next stage. Bank selection is
//  ping-pong, so each stage reads one bank and writes the other.
//  Sits between the top-level start/done handshake and the banked
//  coefficient RAMs, twiddle ROM and butterfly array.
// PARAMETERS
//  LOG_N     11  log2 transform size; also the number of stages
//  LOG_P     7   log2 parallel lanes (butterfly width)
//  PIPE_LAT  8   read-to-write latency of memory+butterfly path, cycles (>=1)
//  CNT_W     LOG_N-LOG_P (4)  beat counter width; beats/stage = 2**CNT_W
//  STG_W     4   stage index width, >= clog2(LOG_N)
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous, active-high reset
//  in_start   in   1            one-cycle start pulse; honoured only when idle
//  rd_en      out  1            read beat valid
//  rd_addr    out  CNT_W        read beat index within stage
//  wr_en      out  1            write beat valid (rd_en delayed PIPE_LAT)
//  wr_addr    out  CNT_W        write beat index (rd_addr delayed PIPE_LAT)
//  stage_idx  out  STG_W        current stage, 0..LOG_N-1
//  tw_addr    out  STG_W+CNT_W  twiddle ROM address = {stage_idx, rd_addr}
//  bank_sel   out  1            read bank = bank_sel, write bank = ~bank_sel
//  busy       out  1            high from first ISSUE cycle through final DRAIN
//  done       out  1            one-cycle pulse after last write of last stage
// BEHAVIOUR
//  - Reset: state=IDLE; every output is 0; delay line flushed.
//    No wr_en is emitted after reset for beats issued before it.
//  - All outputs registered. in_start sampled at edge k -> first rd_en at k+1.
//  - FSM states: IDLE, ISSUE, DRAIN, DONE.
//    IDLE : in_start=1 -> ISSUE, with cnt=0, stage=0, bank_sel=0.
//    ISSUE: rd_en=1, rd_addr=cnt, cnt++ each cycle; at cnt==2**CNT_W-1 -> DRAIN, cnt=0.
//    DRAIN: rd_en=0 for exactly PIPE_LAT cycles; drain counter counts 0..PIPE_LAT-1.
//           At the end, if stage==LOG_N-1 -> DONE.
//           Otherwise stage++, bank_sel toggles, -> ISSUE.
//    DONE : done=1 for one cycle, busy=0 -> IDLE. bank_sel is held, so it
//           names the result bank (LOG_N odd -> 1); it clears on next start.
//  - Writes: the last write of a stage lands in the final DRAIN cycle.
//    The next stage's first read follows on the next cycle, with no overlap.
//  - Cycles from first rd_en to done: LOG_N*(2**CNT_W+PIPE_LAT) = 264 at defaults.
//  - in_start while busy or in DONE is ignored. It does not queue and does
//    not restart the sequence.
//  - rst asserted mid-operation aborts on the next edge: IDLE, all outputs 0,
//    no done pulse.
//  - Counters wrap only by FSM control. cnt never exceeds 2**CNT_W-1, and
//    stage never exceeds LOG_N-1.
//  - tw_addr is a zero-extended concatenation with no arithmetic;
//    its width is STG_W+CNT_W.
// STRUCTURE
//  - Shared package ntt_ctrl_pkg holds:
//    state enum (IDLE, ISSUE, DRAIN, DONE), with explicit 2-bit encoding;
//    localparams LOG_N, LOG_P, CNT_W, STG_W, BEATS=2**CNT_W.
//  - Sub-module ntt_wr_delay_line: a PIPE_LAT-deep shift register of
//    {rd_en, rd_addr} producing {wr_en, wr_addr}, with sync reset clearing
//    every stage.
//  - The top level holds the FSM, beat counter, drain counter, stage
//    counter and bank toggle.
// TESTING
//  1. Reset -> start pulse at cycle 0 -> rd_en high at cycles 1..16,
//     rd_addr 0..15. wr_en high at cycles 9..24, wr_addr 0..15.
//     Second-stage rd_en starts at cycle 25, with stage_idx=1 and bank_sel=1.
//  2. Full run -> 11 stages, bank_sel toggles per stage, tw_addr = {stage,beat}.
//     done pulses exactly once at cycle 265. busy is low at 265 and
//     bank_sel ends at 1.
//  3. in_start pulsed at cycles 5, 100 and 265 (the DONE cycle) -> no
//     effect on the sequence; exactly one done pulse; no restart.
//  4. rst asserted at cycle 30, mid-ISSUE of stage 1 -> next cycle all
//     outputs 0. No wr_en afterwards and no done pulse. A fresh start then
//     reproduces the timing of test 1.
//  5. PIPE_LAT=1 build -> DRAIN lasts 1 cycle and the stage period is 17
//     cycles. The last write coincides with the final DRAIN cycle, and
//     done comes 11*17+1 cycles after start.
//  6. Back-to-back runs: start in the cycle after done -> second run is
//     cycle-identical to the first, starting at stage 0 with bank_sel=0.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT stage sequencer.
// Transform geometry and the FSM state encoding.
package ntt_ctrl_pkg;

    localparam int LOG_N = 11;
    localparam int LOG_P = 7;
    localparam int CNT_W = LOG_N - LOG_P;
    localparam int STG_W = 4;
    localparam int BEATS = 2 ** CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_wr_delay_line.sv
// Shift register regenerating write beats from read beats.
// Reset clears every stage so no stale write survives an abort.
module ntt_wr_delay_line #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_en,
    input  logic [W-1:0] in_addr,
    output logic         out_en,
    output logic [W-1:0] out_addr
);

    logic [W:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                sr[i] <= '0;
        end else begin
            sr[0] <= {in_en, in_addr};
            for (int i = 1; i < DEPTH; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign {out_en, out_addr} = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Steps the NTT datapath through LOG_N stages of BEATS read beats,
// draining the read-to-write pipeline between stages.
module ntt_stage_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_start,
    output logic                   rd_en,
    output logic [CNT_W-1:0]       rd_addr,
    output logic                   wr_en,
    output logic [CNT_W-1:0]       wr_addr,
    output logic [STG_W-1:0]       stage_idx,
    output logic [STG_W+CNT_W-1:0] tw_addr,
    output logic                   bank_sel,
    output logic                   busy,
    output logic                   done
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG_N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DRN_W-1:0] drn, drn_n;
    logic [STG_W-1:0] stage, stage_n;
    logic             bank, bank_n;
    logic             rd_en_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            drn   <= '0;
            stage <= '0;
            bank  <= 1'b0;
            rd_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            drn   <= drn_n;
            stage <= stage_n;
            bank  <= bank_n;
            rd_en <= rd_en_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        drn_n   = drn;
        stage_n = stage;
        bank_n  = bank;
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    state_n = ISSUE;
                    cnt_n   = '0;
                    drn_n   = '0;
                    stage_n = '0;
                    bank_n  = 1'b0;
                end
            end
            ISSUE: begin
                if (cnt == CNT_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                    drn_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drn == DRN_LAST) begin
                    drn_n  = '0;
                    // Toggle on the last stage too: bank_sel then names the result bank.
                    bank_n = ~bank;
                    if (stage == STG_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage + 1'b1;
                    end
                end else begin
                    drn_n = drn + 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_en_d = (state_n == ISSUE);
        busy_d  = (state_n == ISSUE) || (state_n == DRAIN);
        done_d  = (state_n == DONE);
    end

    assign rd_addr   = cnt;
    assign stage_idx = stage;
    assign bank_sel  = bank;
    assign tw_addr   = {stage, cnt};

    ntt_wr_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (CNT_W)
    ) u_wr_delay (
        .clk      (clk),
        .rst      (rst),
        .in_en    (rd_en),
        .in_addr  (rd_addr),
        .out_en   (wr_en),
        .out_addr (wr_addr)
    );

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for the NTT stage sequencer.
// Checks default and single-cycle-latency builds.
module tb_ntt_stage_sequencer;
    import ntt_ctrl_pkg::*;

    typedef struct packed {
        logic       rd_en;
        logic [3:0] rd_addr;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [3:0] stage;
        logic [7:0] tw;
        logic       bank;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int   t;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;

    logic       rd_en0, wr_en0, bank0, busy0, done0;
    logic [3:0] rd_addr0, wr_addr0, stage0;
    logic [7:0] tw0;
    logic       rd_en1, wr_en1, bank1, busy1, done1;
    logic [3:0] rd_addr1, wr_addr1, stage1;
    logic [7:0] tw1;

    int nvec = 0;
    int nmiss = 0;
    obs_t lg [0:299];
    vec_t tbl [13];

    always #5 clk = ~clk;

    ntt_stage_sequencer #(.PIPE_LAT(8)) u_dut (
        .clk(clk), .rst(rst), .in_start(start),
        .rd_en(rd_en0), .rd_addr(rd_addr0),
        .wr_en(wr_en0), .wr_addr(wr_addr0),
        .stage_idx(stage0), .tw_addr(tw0),
        .bank_sel(bank0), .busy(busy0), .done(done0)
    );

    ntt_stage_sequencer #(.PIPE_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_start(start1),
        .rd_en(rd_en1), .rd_addr(rd_addr1),
        .wr_en(wr_en1), .wr_addr(wr_addr1),
        .stage_idx(stage1), .tw_addr(tw1),
        .bank_sel(bank1), .busy(busy1), .done(done1)
    );

    function automatic obs_t cap0();
        return {rd_en0, rd_addr0, wr_en0, wr_addr0,
                stage0, tw0, bank0, busy0, done0};
    endfunction

    function automatic obs_t cap1();
        return {rd_en1, rd_addr1, wr_en1, wr_addr1,
                stage1, tw1, bank1, busy1, done1};
    endfunction

    function automatic obs_t mk(bit r, int ra, bit w, int wa,
                                int st, int tw, bit bk, bit by, bit dn);
        obs_t e;
        e.rd_en   = r;
        e.rd_addr = 4'(ra);
        e.wr_en   = w;
        e.wr_addr = 4'(wa);
        e.stage   = 4'(st);
        e.tw      = 8'(tw);
        e.bank    = bk;
        e.busy    = by;
        e.done    = dn;
        return e;
    endfunction

    // Closed-form timeline of one run started in cycle 0.
    function automatic obs_t exp_obs(int t, int lat);
        obs_t e;
        int per, last, s, o;
        per  = 16 + lat;
        last = 11 * per;
        e    = '0;
        if (t >= 1 && t <= last) begin
            s = (t - 1) / per;
            o = (t - 1) % per;
            e.busy  = 1'b1;
            e.stage = 4'(s);
            e.bank  = s[0];
            if (o < 16) begin
                e.rd_en   = 1'b1;
                e.rd_addr = 4'(o);
            end
            if (o >= lat && o < 16 + lat) begin
                e.wr_en   = 1'b1;
                e.wr_addr = 4'(o - lat);
            end
            e.tw = {e.stage, e.rd_addr};
        end else if (t > last) begin
            e.stage = 4'd10;
            e.tw    = 8'hA0;
            e.bank  = 1'b1;
            e.done  = (t == last + 1);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int t,
                       input obs_t act, input obs_t exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmiss++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run(input int n, input bit which, input int p0,
                       input int p1, input int p2, input int rst_at);
        for (int t = 0; t < n; t++) begin
            if (which)
                start1 = (t == 0);
            else
                start = (t == 0) || (t == p0) || (t == p1) || (t == p2);
            rst = (t == rst_at);
            @(posedge clk);
            #1;
            lg[t+1] = which ? cap1() : cap0();
        end
        start  = 1'b0;
        start1 = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic sweep(input string nm, input int from,
                         input int to, input int lat);
        for (int t = from; t <= to; t++)
            chk(nm, t, lg[t], exp_obs(t, lat));
    endtask

    function automatic int count_done(input int n);
        int c = 0;
        for (int t = 1; t <= n; t++)
            if (lg[t].done === 1'b1) c++;
        return c;
    endfunction

    initial begin
        tbl[0]  = '{1,   mk(1, 0,  0, 0,  0,  8'h00, 0, 1, 0)};
        tbl[1]  = '{8,   mk(1, 7,  0, 0,  0,  8'h07, 0, 1, 0)};
        tbl[2]  = '{9,   mk(1, 8,  1, 0,  0,  8'h08, 0, 1, 0)};
        tbl[3]  = '{16,  mk(1, 15, 1, 7,  0,  8'h0F, 0, 1, 0)};
        tbl[4]  = '{17,  mk(0, 0,  1, 8,  0,  8'h00, 0, 1, 0)};
        tbl[5]  = '{24,  mk(0, 0,  1, 15, 0,  8'h00, 0, 1, 0)};
        tbl[6]  = '{25,  mk(1, 0,  0, 0,  1,  8'h10, 1, 1, 0)};
        tbl[7]  = '{40,  mk(1, 15, 1, 7,  1,  8'h1F, 1, 1, 0)};
        tbl[8]  = '{241, mk(1, 0,  0, 0,  10, 8'hA0, 0, 1, 0)};
        tbl[9]  = '{256, mk(1, 15, 1, 7,  10, 8'hAF, 0, 1, 0)};
        tbl[10] = '{264, mk(0, 0,  1, 15, 10, 8'hA0, 0, 1, 0)};
        tbl[11] = '{265, mk(0, 0,  0, 0,  10, 8'hA0, 1, 0, 1)};
        tbl[12] = '{266, mk(0, 0,  0, 0,  10, 8'hA0, 1, 0, 0)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut", 0, cap0(), '0);
        chk("reset_dut1", 0, cap1(), '0);
        rst = 1'b0;

        // Full run; next start lands in the cycle after done.
        run(266, 0, -1, -1, -1, -1);
        foreach (tbl[i])
            chk("table", tbl[i].t, lg[tbl[i].t], tbl[i].e);
        sweep("full_run", 1, 266, 8);
        chk_int("done_once", count_done(266), 1);

        run(270, 0, -1, -1, -1, -1);
        sweep("back_to_back", 1, 270, 8);
        chk_int("done_once_b2b", count_done(270), 1);

        repeat (3) @(posedge clk);
        #1;
        run(280, 0, 5, 100, 265, -1);
        sweep("ignored_start", 1, 280, 8);
        chk_int("done_once_ign", count_done(280), 1);

        run(60, 0, -1, -1, -1, 30);
        sweep("pre_abort", 1, 30, 8);
        for (int t = 31; t <= 60; t++)
            chk("abort", t, lg[t], '0);
        chk_int("no_done_abort", count_done(60), 0);
        run(270, 0, -1, -1, -1, -1);
        sweep("after_abort", 1, 270, 8);

        run(200, 1, -1, -1, -1, -1);
        sweep("lat1", 1, 200, 1);
        chk("lat1_done", 188, lg[188], mk(0, 0, 0, 0, 10, 8'hA0, 1, 0, 1));
        chk_int("done_once_lat1", count_done(200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
